// File: rtl/ex_stage.sv
// Execute stage of the 5-stage 32-bit MIPS-style pipeline.
// Forwards operands from MEM/WB, runs the ALU and registers the result,
// store data, destination index and control bits into EX/MEM.
// Optional feature: define EX_OVERFLOW_EN to add the registered EXOverflow
// output (signed overflow flag for ADD and SUB).
module ex_stage (
   input  logic        Clk,
   input  logic        ResetN,
   input  logic        MEMRegWrite,
   input  logic [31:0] MEMData,
   input  logic [4:0]  MEMRd,
   input  logic        WBRegWrite,
   input  logic [31:0] WBData,
   input  logic [4:0]  WBRd,
   input  logic        ALUSrc,
   input  logic [2:0]  ALUControl,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        RegWrite,
   input  logic [31:0] DataA,
   input  logic [31:0] DataB,
   input  logic [31:0] SignExtend,
   input  logic [4:0]  Rs,
   input  logic [4:0]  Rt,
   input  logic [4:0]  Rd,
   output logic        EXRegWrite,
   output logic        EXMemRead,
   output logic        EXMemWrite,
   output logic [4:0]  EXRd,
   output logic [31:0] EXData,
   output logic [31:0] EXALUData
`ifdef EX_OVERFLOW_EN
   ,
   output logic        EXOverflow
`endif
);

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_XOR  = 3'b011,
      ALU_NOR  = 3'b100,
      ALU_ZERO = 3'b101,
      ALU_SUB  = 3'b110,
      ALU_SLT  = 3'b111
   } alu_op_e;

   logic [31:0] fwd_a;
   logic [31:0] fwd_b;
   logic [31:0] op2;
   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] alu_res;
   logic        ovf;
   alu_op_e     op;

   logic        regwrite_q, regwrite_d;
   logic        memread_q,  memread_d;
   logic        memwrite_q, memwrite_d;
   logic [4:0]  rd_q,       rd_d;
   logic [31:0] data_q,     data_d;
   logic [31:0] alu_q,      alu_d;
   logic        ovf_q,      ovf_d;

   // Operand forwarding: MEM beats WB, register 0 is never forwarded.
   always_comb begin
      fwd_a = DataA;
      fwd_b = DataB;
      if (MEMRegWrite && (MEMRd != 5'd0) && (MEMRd == Rs))
         fwd_a = MEMData;
      else if (WBRegWrite && (WBRd != 5'd0) && (WBRd == Rs))
         fwd_a = WBData;
      if (MEMRegWrite && (MEMRd != 5'd0) && (MEMRd == Rt))
         fwd_b = MEMData;
      else if (WBRegWrite && (WBRd != 5'd0) && (WBRd == Rt))
         fwd_b = WBData;
   end

   assign op2  = ALUSrc ? SignExtend : fwd_b;
   assign sum  = fwd_a + op2;
   assign diff = fwd_a - op2;
   assign op   = alu_op_e'(ALUControl);

   // ALU result and signed-overflow flag for the selected operation.
   always_comb begin
      alu_res = '0;
      ovf     = 1'b0;
      case (op)
         ALU_AND:  alu_res = fwd_a & op2;
         ALU_OR:   alu_res = fwd_a | op2;
         ALU_ADD: begin
            alu_res = sum;
            ovf     = (fwd_a[31] == op2[31]) && (sum[31] != fwd_a[31]);
         end
         ALU_XOR:  alu_res = fwd_a ^ op2;
         ALU_NOR:  alu_res = ~(fwd_a | op2);
         ALU_ZERO: alu_res = '0;
         ALU_SUB: begin
            alu_res = diff;
            ovf     = (fwd_a[31] != op2[31]) && (diff[31] != fwd_a[31]);
         end
         ALU_SLT:  alu_res = {31'd0, ($signed(fwd_a) < $signed(op2))};
         default:  alu_res = '0;
      endcase
   end

   // Next-state values for the EX/MEM pipeline register.
   always_comb begin
      regwrite_d = RegWrite;
      memread_d  = MemRead;
      memwrite_d = MemWrite;
      rd_d       = Rd;
      data_d     = fwd_b;
      alu_d      = alu_res;
      ovf_d      = ovf;
   end

   // EX/MEM pipeline register with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
         alu_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         alu_q      <= alu_d;
         ovf_q      <= ovf_d;
      end
   end

   assign EXRegWrite = regwrite_q;
   assign EXMemRead  = memread_q;
   assign EXMemWrite = memwrite_q;
   assign EXRd       = rd_q;
   assign EXData     = data_q;
   assign EXALUData  = alu_q;

`ifdef EX_OVERFLOW_EN
   assign EXOverflow = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal checks plus randomized
// stimulus compared each cycle against a behavioural model.
module tb_ex_stage;

   logic        Clk = 1'b0;
   logic        ResetN;
   logic        MEMRegWrite, WBRegWrite;
   logic [31:0] MEMData, WBData;
   logic [4:0]  MEMRd, WBRd;
   logic        ALUSrc;
   logic [2:0]  ALUControl;
   logic        MemRead, MemWrite, RegWrite;
   logic [31:0] DataA, DataB, SignExtend;
   logic [4:0]  Rs, Rt, Rd;
   logic        EXRegWrite, EXMemRead, EXMemWrite;
   logic [4:0]  EXRd;
   logic [31:0] EXData, EXALUData;
   logic        ovf_out;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   typedef struct packed {
      logic        rw, mr, mw;
      logic [4:0]  rd;
      logic [31:0] data, alu;
      logic        ovf;
   } exp_t;

   exp_t exp_q;

`ifdef EX_OVERFLOW_EN
   logic EXOverflow;
   assign ovf_out = EXOverflow;
`else
   assign ovf_out = 1'b0;
`endif

   ex_stage dut (
      .Clk(Clk), .ResetN(ResetN),
      .MEMRegWrite(MEMRegWrite), .MEMData(MEMData), .MEMRd(MEMRd),
      .WBRegWrite(WBRegWrite), .WBData(WBData), .WBRd(WBRd),
      .ALUSrc(ALUSrc), .ALUControl(ALUControl),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .DataA(DataA), .DataB(DataB), .SignExtend(SignExtend),
      .Rs(Rs), .Rt(Rt), .Rd(Rd),
      .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead), .EXMemWrite(EXMemWrite),
      .EXRd(EXRd), .EXData(EXData), .EXALUData(EXALUData)
`ifdef EX_OVERFLOW_EN
      , .EXOverflow(EXOverflow)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // Operand value seen by the stage for a given source index.
   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 5'd0) return rf;
      if (MEMRegWrite && MEMRd == idx) return MEMData;
      if (WBRegWrite && WBRd == idx) return WBData;
      return rf;
   endfunction

   function automatic exp_t model();
      exp_t   e;
      logic [31:0] a, b, o;
      longint sa, so, r;
      a  = operand(Rs, DataA);
      b  = operand(Rt, DataB);
      o  = ALUSrc ? SignExtend : b;
      sa = longint'($signed(a));
      so = longint'($signed(o));
      e.rw = RegWrite; e.mr = MemRead; e.mw = MemWrite;
      e.rd = Rd; e.data = b; e.ovf = 1'b0;
      case (ALUControl)
         3'd0: e.alu = a & o;
         3'd1: e.alu = a | o;
         3'd2: begin r = sa + so; e.alu = r[31:0];
                     e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         3'd3: e.alu = a ^ o;
         3'd4: e.alu = ~(a | o);
         3'd5: e.alu = 32'd0;
         3'd6: begin r = sa - so; e.alu = r[31:0];
                     e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         default: e.alu = (sa < so) ? 32'd1 : 32'd0;
      endcase
      return e;
   endfunction

   // Expected EX/MEM register contents, updated like the real pipeline register.
   always @(posedge Clk or negedge ResetN) begin
      if (!ResetN) exp_q <= '0;
      else         exp_q <= model();
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      if (chk_en) begin
         check("cyc_regwrite", {31'd0, EXRegWrite}, {31'd0, exp_q.rw});
         check("cyc_memread",  {31'd0, EXMemRead},  {31'd0, exp_q.mr});
         check("cyc_memwrite", {31'd0, EXMemWrite}, {31'd0, exp_q.mw});
         check("cyc_rd",       {27'd0, EXRd},       {27'd0, exp_q.rd});
         check("cyc_data",     EXData,              exp_q.data);
         check("cyc_alu",      EXALUData,           exp_q.alu);
`ifdef EX_OVERFLOW_EN
         check("cyc_ovf",      {31'd0, ovf_out},    {31'd0, exp_q.ovf});
`endif
      end
   end

   task automatic clear_inputs();
      MEMRegWrite = 0; MEMData = '0; MEMRd = '0;
      WBRegWrite  = 0; WBData  = '0; WBRd  = '0;
      ALUSrc = 0; ALUControl = '0; MemRead = 0; MemWrite = 0; RegWrite = 0;
      DataA = '0; DataB = '0; SignExtend = '0; Rs = '0; Rt = '0; Rd = '0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic alu_op(input string name, input logic [2:0] code, input logic [31:0] want);
      ALUControl = code;
      step();
      check(name, EXALUData, want);
   endtask

   initial begin
      ResetN = 1'b0;
      clear_inputs();
      #1 chk_en = 1'b1;
      repeat (2) @(posedge Clk);
      #3 ResetN = 1'b1;

      // Plain ALU, no forwarding match.
      DataA = 32'd7; DataB = 32'd3; Rs = 5'd1; Rt = 5'd2;
      alu_op("add",  3'b010, 32'd10);
      alu_op("sub",  3'b110, 32'd4);
      alu_op("and",  3'b000, 32'd3);
      alu_op("or",   3'b001, 32'd7);
      alu_op("xor",  3'b011, 32'd4);
      alu_op("nor",  3'b100, 32'hFFFF_FFF8);
      alu_op("slt0", 3'b111, 32'd0);
      DataA = 32'hFFFF_FFFF;
      alu_op("slt1", 3'b111, 32'd1);
      alu_op("zero", 3'b101, 32'd0);

      // Immediate add with store.
      ALUSrc = 1; SignExtend = 32'hFFFF_FFFC; DataA = 32'd100; DataB = 32'h55;
      MemWrite = 1;
      alu_op("imm_add", 3'b010, 32'd96);
      check("imm_data", EXData, 32'h55);
      check("imm_memwrite", {31'd0, EXMemWrite}, 32'd1);

      // Forwarding priority.
      clear_inputs();
      Rs = 5'd4; Rt = 5'd4; DataA = 32'd1000; DataB = 32'd2000;
      MEMRegWrite = 1; MEMRd = 5'd4; MEMData = 32'd11;
      WBRegWrite  = 1; WBRd  = 5'd4; WBData  = 32'd22;
      alu_op("fwd_mem_alu", 3'b010, 32'd22);
      check("fwd_mem_data", EXData, 32'd11);
      MEMRegWrite = 0;
      alu_op("fwd_wb_alu", 3'b010, 32'd44);
      check("fwd_wb_data", EXData, 32'd22);

      // Register 0 never forwarded.
      clear_inputs();
      MEMRegWrite = 1; MEMRd = 5'd0; MEMData = 32'd9; DataA = 32'd0; DataB = 32'd1;
      alu_op("reg0", 3'b010, 32'd1);

`ifdef EX_OVERFLOW_EN
      clear_inputs();
      Rs = 5'd1; Rt = 5'd2;
      DataA = 32'h7FFF_FFFF; DataB = 32'd1;
      alu_op("ovf_add", 3'b010, 32'h8000_0000);
      check("ovf_add_flag", {31'd0, ovf_out}, 32'd1);
      DataA = 32'h8000_0000; DataB = 32'd1;
      alu_op("ovf_sub", 3'b110, 32'h7FFF_FFFF);
      check("ovf_sub_flag", {31'd0, ovf_out}, 32'd1);
      DataA = 32'd5; DataB = 32'd3;
      alu_op("ovf_none", 3'b010, 32'd8);
      check("ovf_none_flag", {31'd0, ovf_out}, 32'd0);
`endif

      // Asynchronous reset mid-run with nonzero inputs.
      clear_inputs();
      DataA = 32'd3; DataB = 32'd4; Rt = 5'd2; RegWrite = 1; MemRead = 1;
      MemWrite = 1; Rd = 5'd9; ALUControl = 3'b010;
      step();
      ResetN = 1'b0;
      #1;
      check("rst_regwrite", {31'd0, EXRegWrite}, 32'd0);
      check("rst_memread",  {31'd0, EXMemRead},  32'd0);
      check("rst_memwrite", {31'd0, EXMemWrite}, 32'd0);
      check("rst_rd",       {27'd0, EXRd},       32'd0);
      check("rst_data",     EXData,              32'd0);
      check("rst_alu",      EXALUData,           32'd0);
      #1 ResetN = 1'b1;
      clear_inputs();
      RegWrite = 1; Rd = 5'd5;
      step();
      check("post_rst_regwrite", {31'd0, EXRegWrite}, 32'd1);
      check("post_rst_rd", {27'd0, EXRd}, 32'd5);

      // Randomized traffic; small index range makes forwarding hits common.
      for (int i = 0; i < 400; i++) begin
         MEMRegWrite = 1'($urandom_range(1));
         WBRegWrite  = 1'($urandom_range(1));
         MEMRd = 5'($urandom_range(7));
         WBRd  = 5'($urandom_range(7));
         Rs    = 5'($urandom_range(7));
         Rt    = 5'($urandom_range(7));
         Rd    = 5'($urandom_range(31));
         MEMData = $urandom; WBData = $urandom;
         DataA   = ($urandom_range(3) == 0) ? 32'h7FFF_FFFF : $urandom;
         DataB   = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
         SignExtend = $urandom;
         ALUSrc     = 1'($urandom_range(1));
         ALUControl = 3'($urandom_range(7));
         MemRead  = 1'($urandom_range(1));
         MemWrite = 1'($urandom_range(1));
         RegWrite = 1'($urandom_range(1));
         if (i == 200) begin
            #2 ResetN = 1'b0;
            #2 ResetN = 1'b1;
         end
         step();
      end

      @(negedge Clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage 32-bit MIPS-style pipeline.
- Sits between the ID stage and the MEM stage.
- Resolves operand hazards by forwarding from the MEM and WB stages, then performs the ALU operation.
- Registers the result, store data, destination register and control bits into the EX/MEM pipeline register.

Parameters:
- None. Data width fixed at 32 bits; register index fixed at 5 bits.

Ports:
Clk  in  1  pipeline clock; all state updates on rising edge
ResetN  in  1  asynchronous active-low reset
MEMRegWrite  in  1  instruction now in MEM stage writes a register
MEMData  in  32  result of instruction in MEM stage
MEMRd  in  5  destination register of instruction in MEM stage
WBRegWrite  in  1  instruction now in WB stage writes a register
WBData  in  32  result of instruction in WB stage
WBRd  in  5  destination register of instruction in WB stage
ALUSrc  in  1  1 = second ALU operand is SignExtend; 0 = forwarded B operand
ALUControl  in  3  ALU operation select
MemRead  in  1  instruction is a load
MemWrite  in  1  instruction is a store
RegWrite  in  1  instruction writes a register
DataA  in  32  register file value of Rs
DataB  in  32  register file value of Rt
SignExtend  in  32  sign-extended immediate
Rs  in  5  source register A index
Rt  in  5  source register B index
Rd  in  5  destination index, already selected by ID
EXRegWrite  out  1  registered RegWrite
EXMemRead  out  1  registered MemRead
EXMemWrite  out  1  registered MemWrite
EXRd  out  5  registered Rd
EXData  out  32  registered forwarded B operand (store data)
EXALUData  out  32  registered ALU result

Behaviour:
- Reset: while ResetN = 0, all outputs are 0. Reset is asynchronous on assertion; outputs update normally from the first rising edge after release.
- Forward A, combinational:
  - If MEMRegWrite && MEMRd != 0 && MEMRd == Rs, then A = MEMData.
  - Else if WBRegWrite && WBRd != 0 && WBRd == Rs, then A = WBData.
  - Else A = DataA.
  - MEM has priority over WB when both match.
- Forward B: same rules using Rt and DataB.
- Register 0 is never forwarded; DataA/DataB are used as-is for index 0.
- Second operand: Op2 = ALUSrc ? SignExtend : B.
- ALUControl encoding (all arithmetic modulo 2^32, no traps):
  - 000: A AND Op2
  - 001: A OR Op2
  - 010: A + Op2
  - 011: A XOR Op2
  - 100: NOR(A, Op2)
  - 101: 0
  - 110: A − Op2
  - 111: SLT, signed; result 1 if A < Op2, else 0
- On each rising Clk edge (reset deasserted), register:
  - EXALUData = ALU result
  - EXData = B (always the forwarded value, regardless of ALUSrc)
  - EXRd = Rd
  - EXRegWrite, EXMemRead, EXMemWrite = RegWrite, MemRead, MemWrite
- Latency: one cycle, inputs to outputs.
- No stall or flush input. Bubbles arrive from ID as all-zero control bits and pass through unchanged.
- The block's own EX outputs are not fed back for forwarding; load-use hazards are stalled by ID.

Optional Feature:
- Macro EX_OVERFLOW_EN.
- When defined: adds output EXOverflow (1 bit), registered like the other outputs and reset to 0.
  - Set for op 010 when both operands share a sign and the result sign differs.
  - Set for op 110 when A and Op2 signs differ and the result sign differs from A.
  - 0 for all other ops.
- Result is still written; no trap.
- When undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset: ResetN = 0 mid-run with nonzero inputs → all outputs 0 immediately. Release, then one edge with RegWrite = 1, Rd = 5 → EXRegWrite = 1, EXRd = 5.
- Plain ALU: DataA = 7, DataB = 3, ALUSrc = 0, no forward match; walk all codes:
  - ADD → 10
  - SUB → 4
  - AND → 3
  - OR → 7
  - XOR → 4
  - NOR → 0xFFFFFFF8
  - SLT → 0
  - DataA = 0xFFFFFFFF with SLT → 1
  - 101 → 0
- Immediate/store: ALUSrc = 1, SignExtend = 0xFFFFFFFC, DataA = 100, ADD, MemWrite = 1, DataB = 0x55 → EXALUData = 96, EXData = 0x55, EXMemWrite = 1.
- Forward priority: Rs = Rt = 4; MEM (RegWrite = 1, Rd = 4, Data = 11); WB (RegWrite = 1, Rd = 4, Data = 22); ADD → EXALUData = 22, EXData = 11. Clear MEMRegWrite → 44.
- Register 0: Rs = 0, MEMRd = 0, MEMRegWrite = 1, MEMData = 9, DataA = 0, DataB = 1, ADD → EXALUData = 1.
- Overflow (EX_OVERFLOW_EN): 0x7FFFFFFF + 1 → EXALUData = 0x80000000, EXOverflow = 1. 0x80000000 − 1 → EXOverflow = 1. 5 + 3 → EXOverflow = 0.
